i2s_rx: RTL and testbench

- Receive-side I2S block, complementing the existing transmit path (master/LR/data clock dividers plus data shifter).
- Accepts an external I2S stream (bit clock, word-select and serial data) from an ADC or other I2S source.
- All three inputs are oversampled in the system clock domain. The block deserialises left and right words and presents each stereo pair on a valid/ready interface toward the RPi-side logic.
- No I2S pin is used as a clock.

---
 rtl/i2s_rx.sv | 131 +++++++++++++
 tb/tb_i2s_rx.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_rx.sv
// i2s_rx: oversampling I2S receiver.
// bclk, lrclk and sd are sampled in the clk domain; no I2S pin is used as a clock.
// Each left/right word pair is presented on a valid/ready interface.
// Words are MSB first and left-aligned in DATA_W bits: extra slot bits are
// dropped and short words are zero-padded.
module i2s_rx #(
  parameter int DATA_W = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i2s_bclk,
  input  logic              i2s_lrclk,
  input  logic              i2s_sd,
  output logic [DATA_W-1:0] left_data,
  output logic [DATA_W-1:0] right_data,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic              overflow
);

  localparam int                CW      = $clog2(DATA_W + 1);
  localparam logic [CW-1:0]     CNT_MAX = CW'(DATA_W);
  localparam logic [DATA_W-1:0] MSB     = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {WAIT_SYNC, LEFT, RIGHT} state_t;

  logic              bclk_s1, bclk_s2, bclk_s3;
  logic              lr_s1, lr_s2;
  logic              sd_s1, sd_s2;
  logic              rise_q, lr_q, sd_q;
  state_t            state;
  logic              lr_prev;
  logic [DATA_W-1:0] shreg;
  logic [CW-1:0]     bit_cnt;
  logic [DATA_W-1:0] left_stage;
  logic [DATA_W-1:0] pair_r;
  logic              commit;

  // Two-flop synchronisers plus a third bclk flop for edge detection.
  // These carry no state worth clearing, so they are left out of reset; that
  // also keeps a reset from faking a bclk edge when bclk happens to be high.
  always_ff @(posedge clk) begin
    bclk_s1 <= i2s_bclk;
    bclk_s2 <= bclk_s1;
    bclk_s3 <= bclk_s2;
    lr_s1   <= i2s_lrclk;
    lr_s2   <= lr_s1;
    sd_s1   <= i2s_sd;
    sd_s2   <= sd_s1;
  end

  // Register the bclk rising-edge pulse with the lr/sd values it samples.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rise_q <= 1'b0;
      lr_q   <= 1'b0;
      sd_q   <= 1'b0;
    end else begin
      rise_q <= bclk_s2 & ~bclk_s3;
      lr_q   <= lr_s2;
      sd_q   <= sd_s2;
    end
  end

  // Frame FSM: track lr slot boundaries, deserialise, stage left, commit pairs.
  // A boundary rise carries the LSB of the slot just ended, so it only clears
  // the shifter; the next word's MSB arrives on the following rise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= WAIT_SYNC;
      lr_prev    <= 1'b0;
      shreg      <= '0;
      bit_cnt    <= '0;
      left_stage <= '0;
      pair_r     <= '0;
      commit     <= 1'b0;
    end else begin
      commit <= 1'b0;
      if (rise_q) begin
        lr_prev <= lr_q;
        if (lr_q != lr_prev) begin
          shreg   <= '0;
          bit_cnt <= '0;
          unique case (state)
            // only a falling lr (start of a left slot) gives frame alignment
            WAIT_SYNC: if (!lr_q) state <= LEFT;
            // lr was 0 in LEFT, so any boundary here is the rise into RIGHT
            LEFT: begin
              left_stage <= shreg;
              state      <= RIGHT;
            end
            // and here it is the fall that closes the frame
            RIGHT: begin
              pair_r <= shreg;
              commit <= 1'b1;
              state  <= LEFT;
            end
            default: state <= WAIT_SYNC;
          endcase
        end else if (bit_cnt < CNT_MAX) begin
          shreg   <= shreg | ({DATA_W{sd_q}} & (MSB >> bit_cnt));
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
    end
  end

  // Output register and handshake. A new pair replaces the held one only if
  // the slot is free or being consumed this same clk; otherwise it is dropped
  // and overflow latches until reset. left_stage is not touched again until
  // the next left->right boundary, so it is still the committed left word here.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      left_data    <= '0;
      right_data   <= '0;
      sample_valid <= 1'b0;
      overflow     <= 1'b0;
    end else if (commit) begin
      if (!sample_valid || sample_ready) begin
        left_data    <= left_stage;
        right_data   <= pair_r;
        sample_valid <= 1'b1;
      end else begin
        overflow <= 1'b1;
      end
    end else if (sample_valid && sample_ready) begin
      sample_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_i2s_rx.sv
// tb_i2s_rx: table-driven and random I2S frames with a pair scoreboard.
module tb_i2s_rx;

  localparam int DATA_W = 24;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              i2s_bclk = 1'b0;
  logic              i2s_lrclk = 1'b1;
  logic              i2s_sd = 1'b0;
  logic              sample_ready = 1'b0;
  logic [DATA_W-1:0] left_data, right_data;
  logic              sample_valid, overflow;

  i2s_rx #(.DATA_W(DATA_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i2s_bclk     (i2s_bclk),
    .i2s_lrclk    (i2s_lrclk),
    .i2s_sd       (i2s_sd),
    .left_data    (left_data),
    .right_data   (right_data),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                len;
    logic [31:0]       l;
    logic [31:0]       r;
    logic [DATA_W-1:0] el;
    logic [DATA_W-1:0] er;
  } vec_t;

  int   tests = 0;
  int   fails = 0;
  int   half = 3;          // clk cycles per bclk half period
  bit   at_left0 = 1'b0;   // boundary period of a left slot already sent
  logic pend_lsb = 1'b0;   // LSB of the previous word, sent on the next boundary
  bit   mon_en = 1'b0;
  bit   rnd_on = 1'b0;
  logic [2*DATA_W-1:0] exp_q[$];

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One bclk period: lr/sd change with the falling bclk, sampled on the rise.
  task automatic bit_period(input logic lrv, input logic sdv);
    @(negedge clk);
    i2s_bclk = 1'b0; i2s_lrclk = lrv; i2s_sd = sdv;
    repeat (half) @(negedge clk);
    i2s_bclk = 1'b1;
    repeat (half - 1) @(negedge clk);
  endtask

  // One lr phase of len periods carrying word w (len bits, MSB first).
  // Period 0 carries the previous word's LSB; w's LSB goes out on the next one.
  task automatic send_phase(input logic lrv, input logic [31:0] w, input int len);
    int j0;
    j0 = (at_left0 && !lrv) ? 1 : 0;
    at_left0 = 1'b0;
    for (int j = j0; j < len; j++) bit_period(lrv, (j == 0) ? pend_lsb : w[len - j]);
    pend_lsb = w[0];
  endtask

  task automatic send_frame(input logic [31:0] l, input logic [31:0] r, input int len);
    send_phase(1'b0, l, len);
    send_phase(1'b1, r, len);
  endtask

  // Falling lr boundary that closes the last frame sent.
  task automatic close_frame();
    bit_period(1'b0, pend_lsb);
    at_left0 = 1'b1;
  endtask

  // Same as close_frame, but counts clk edges from the bclk rise to valid.
  task automatic close_lat(output int lat);
    @(negedge clk);
    i2s_bclk = 1'b0; i2s_lrclk = 1'b0; i2s_sd = pend_lsb;
    repeat (half) @(negedge clk);
    i2s_bclk = 1'b1;
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (sample_valid && lat == 0) lat = k;
    end
    at_left0 = 1'b1;
  endtask

  // Partial right slot straight after reset: its lr rise must be ignored.
  task automatic sync_pre();
    send_phase(1'b1, $urandom, 7);
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    @(negedge clk); rst_n = 1'b0;
    wait_clk(3); #1;
    chk("rst_left", 48'(left_data), 48'h0);
    chk("rst_right", 48'(right_data), 48'h0);
    chk("rst_valid", 48'(sample_valid), 48'h0);
    chk("rst_overflow", 48'(overflow), 48'h0);
    @(negedge clk); rst_n = 1'b1;
    at_left0 = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 400) begin
      @(negedge clk);
      k++;
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s: %0d pairs still outstanding, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // Bit-level reference: the word's serial bits up to (not including) the one
  // that lands on the next boundary rise, left-aligned and capped at DATA_W.
  function automatic logic [DATA_W-1:0] model(input logic [31:0] w, input int len);
    logic [DATA_W-1:0] res;
    res = '0;
    for (int k = 0; k < len - 1 && k < DATA_W; k++) res[DATA_W-1-k] = w[len-1-k];
    return res;
  endfunction

  // Monitor: pops the scoreboard on each handshake and checks that a pair
  // held with ready low stays put.
  logic              m_hold = 1'b0;
  logic [DATA_W-1:0] m_l, m_r;
  logic [2*DATA_W-1:0] m_e;
  initial begin
    forever begin
      @(negedge clk); #1;
      if (!mon_en) begin
        m_hold = 1'b0;
      end else begin
        if (m_hold) begin
          chk("hold_valid", 48'(sample_valid), 48'h1);
          chk("hold_left", 48'(left_data), 48'(m_l));
          chk("hold_right", 48'(right_data), 48'(m_r));
        end
        if (sample_valid && sample_ready) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_pair: got %h/%h, expected no pair", left_data, right_data);
          end else begin
            m_e = exp_q.pop_front();
            chk("pair_left", 48'(left_data), 48'(m_e[2*DATA_W-1:DATA_W]));
            chk("pair_right", 48'(right_data), 48'(m_e[DATA_W-1:0]));
          end
        end
        m_hold = sample_valid && !sample_ready;
        m_l = left_data;
        m_r = right_data;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[$];
    int   lat;
    logic [31:0] wl, wr;
    int   ln;

    // A 16-bit word in a 16-bit slot loses its LSB on the boundary rise;
    // a 17-bit slot carries all 16 bits.
    vt.push_back('{32, {24'hA5A5A5, 8'h00}, {24'h3C3C3C, 8'h00}, 24'hA5A5A5, 24'h3C3C3C});
    vt.push_back('{32, {24'h123456, 8'hFF}, {24'hFEDCBA, 8'h55}, 24'h123456, 24'hFEDCBA});
    vt.push_back('{16, 32'h0000FFFF,        32'h00001234,        24'hFFFE00, 24'h123400});
    vt.push_back('{17, {15'h0, 16'hFFFF, 1'b1}, {15'h0, 16'h1234, 1'b1}, 24'hFFFF00, 24'h123400});
    vt.push_back('{25, {7'h0, 24'h800001, 1'b1}, {7'h0, 24'h7FFFFE, 1'b0}, 24'h800001, 24'h7FFFFE});
    vt.push_back('{24, {8'h0, 24'hABCDEF},  {8'h0, 24'h000001},  24'hABCDEE, 24'h000000});
    vt.push_back('{2,  32'h00000003,        32'h00000001,        24'h800000, 24'h000000});

    // reset state
    wait_clk(4); #1;
    chk("init_left", 48'(left_data), 48'h0);
    chk("init_right", 48'(right_data), 48'h0);
    chk("init_valid", 48'(sample_valid), 48'h0);
    chk("init_overflow", 48'(overflow), 48'h0);
    @(negedge clk); rst_n = 1'b1;
    mon_en = 1'b1;
    sample_ready = 1'b1;

    // table frames back to back after a partial right slot
    sync_pre();
    for (int i = 0; i < vt.size(); i++) begin
      exp_q.push_back({vt[i].el, vt[i].er});
      send_frame(vt[i].l, vt[i].r, vt[i].len);
    end
    close_lat(lat);
    chk("latency", 48'(lat), 48'd5);
    drain("table_drain");
    chk("table_overflow", 48'(overflow), 48'h0);

    // ready low across three frames: first pair held, the rest dropped
    do_reset();
    sample_ready = 1'b0;
    sync_pre();
    exp_q.push_back({24'hA5A5A5, 24'h3C3C3C});
    send_frame({24'hA5A5A5, 8'h00}, {24'h3C3C3C, 8'h00}, 32);
    send_frame({24'h111111, 8'h00}, {24'h222222, 8'h00}, 32);
    #1;
    chk("ovf_f1_valid", 48'(sample_valid), 48'h1);
    chk("ovf_f1_left", 48'(left_data), 48'hA5A5A5);
    chk("ovf_f1_overflow", 48'(overflow), 48'h0);
    close_frame();
    wait_clk(10); #1;
    chk("ovf_f2_overflow", 48'(overflow), 48'h1);
    chk("ovf_f2_left", 48'(left_data), 48'hA5A5A5);
    chk("ovf_f2_right", 48'(right_data), 48'h3C3C3C);
    send_frame({24'h333333, 8'h00}, {24'h444444, 8'h00}, 32);
    close_frame();
    wait_clk(10); #1;
    chk("ovf_f3_left", 48'(left_data), 48'hA5A5A5);
    chk("ovf_f3_valid", 48'(sample_valid), 48'h1);
    @(negedge clk); sample_ready = 1'b1;
    drain("ovf_release");
    exp_q.push_back({24'h555555, 24'h666666});
    send_frame({24'h555555, 8'h00}, {24'h666666, 8'h00}, 32);
    close_frame();
    drain("ovf_next");
    wait_clk(2); #1;
    chk("ovf_sticky", 48'(overflow), 48'h1);
    chk("ovf_valid_low", 48'(sample_valid), 48'h0);

    // reset mid-left slot, resync, and a bclk stall mid-frame
    sample_ready = 1'b0;
    send_phase(1'b0, 32'hDEADBEEF, 12);
    do_reset();
    sample_ready = 1'b1;
    send_phase(1'b0, 32'h0F0F0F0F, 9);
    sync_pre();
    exp_q.push_back({24'hC0FFEE, 24'h0BADF0});
    send_phase(1'b0, {24'hC0FFEE, 8'h00}, 32);
    wait_clk(300); #1;
    chk("stall_valid", 48'(sample_valid), 48'h0);
    send_phase(1'b1, {24'h0BADF0, 8'h00}, 32);
    exp_q.push_back({24'h5A5A5A, 24'h9669AB});
    send_frame({24'h5A5A5A, 8'h00}, {24'h9669AB, 8'h00}, 32);
    close_frame();
    drain("resync_drain");
    chk("resync_overflow", 48'(overflow), 48'h0);

    // clk = 4x bclk, random data, slot lengths and ready
    half = 2;
    rnd_on = 1'b1;
    fork
      begin
        for (int f = 0; f < 200; f++) begin
          ln = $urandom_range(20, 32);
          wl = $urandom;
          wr = $urandom;
          exp_q.push_back({model(wl, ln), model(wr, ln)});
          send_frame(wl, wr, ln);
        end
        close_frame();
        drain("random_drain");
        rnd_on = 1'b0;
      end
      begin
        while (rnd_on) begin
          @(negedge clk);
          sample_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    chk("random_overflow", 48'(overflow), 48'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
